// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: I2S master receiver for a MEMS microphone.
// Generates SCK/WS, deserialises one channel's sample MSB first with the
// standard one-bit delay, then rounds half up and saturates it to OUT_W bits.
// Each result is presented as a one-cycle strobe for the downstream FIR core.
module i2s_mic_rx #(
    parameter int SCK_DIV     = 8,
    parameter int BITS_PER_CH = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int OUT_W       = 16,
    parameter int CHANNEL     = 0,
    parameter int DISCARD     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             i2s_sd,
    output logic             i2s_sck,
    output logic             i2s_ws,
    output logic [OUT_W-1:0] dout,
    output logic             out_en
);

    localparam int DIV_W  = $clog2(SCK_DIV);
    localparam int BIT_W  = $clog2(2 * BITS_PER_CH);
    localparam int DISC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0]  FRAME_LAST = BIT_W'(2 * BITS_PER_CH - 1);
    localparam logic [BIT_W-1:0]  SLOT_LEN   = BIT_W'(BITS_PER_CH);
    localparam logic [BIT_W-1:0]  MSB_POS    = BIT_W'(1);
    localparam logic [BIT_W-1:0]  LSB_POS    = BIT_W'(SAMPLE_BITS);
    localparam logic [DISC_W-1:0] DISC_INIT  = DISC_W'(DISCARD);
    localparam logic              CH_SEL     = (CHANNEL != 0) ? 1'b1 : 1'b0;
    localparam logic [OUT_W-1:0]  POS_MAX    = {1'b0, {(OUT_W-1){1'b1}}};

    // Round half up and saturate. top_bits holds the OUT_W most significant
    // sample bits followed by the first discarded bit (the rounding bit).
    // Only the positive end can overflow (0x7FFF + 1); negative full scale
    // plus a rounding bit always stays in range.
    function automatic logic [OUT_W-1:0] round_sat(input logic [OUT_W:0] top_bits);
        logic [OUT_W:0] trunc_v;
        logic [OUT_W:0] sum_v;
        trunc_v = {top_bits[OUT_W], top_bits[OUT_W:1]};
        sum_v   = trunc_v + {{OUT_W{1'b0}}, top_bits[0]};
        if (!sum_v[OUT_W] && sum_v[OUT_W-1]) begin
            round_sat = POS_MAX;
        end else begin
            round_sat = sum_v[OUT_W-1:0];
        end
    endfunction

    logic [DIV_W-1:0]       div_cnt_r;
    logic                   sck_r;
    logic                   ws_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [SAMPLE_BITS-1:0] shift_r;
    logic                   last_bit_r;
    logic [DISC_W-1:0]      disc_cnt_r;
    logic [OUT_W-1:0]       dout_r;
    logic                   out_en_r;

    logic                   tick_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [BIT_W-1:0]       bit_cnt_nxt_s;
    logic [BIT_W-1:0]       slot_k_s;
    logic                   cap_s;
    logic                   lsb_s;

    assign tick_s        = (div_cnt_r == DIV_LAST);
    assign rise_s        = tick_s & ~sck_r;
    assign fall_s        = tick_s & sck_r;
    assign bit_cnt_nxt_s = (bit_cnt_r == FRAME_LAST) ? {BIT_W{1'b0}} : (bit_cnt_r + BIT_W'(1));
    // ws_r is exactly (bit_cnt_r >= BITS_PER_CH), so it selects the slot offset.
    assign slot_k_s      = ws_r ? (bit_cnt_r - SLOT_LEN) : bit_cnt_r;
    assign cap_s         = rise_s & (ws_r == CH_SEL) & (slot_k_s >= MSB_POS) & (slot_k_s <= LSB_POS);
    assign lsb_s         = cap_s & (slot_k_s == LSB_POS);

    // SCK divider: toggles the bit clock every SCK_DIV clk cycles while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= 1'b0;
        end else if (!en) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            sck_r     <= ~sck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            sck_r     <= sck_r;
        end
    end

    // Frame bit counter and word select; both advance only on SCK falling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            ws_r      <= 1'b0;
        end else if (!en) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            ws_r      <= 1'b0;
        end else if (fall_s) begin
            bit_cnt_r <= bit_cnt_nxt_s;
            ws_r      <= (bit_cnt_nxt_s >= SLOT_LEN);
        end else begin
            bit_cnt_r <= bit_cnt_r;
            ws_r      <= ws_r;
        end
    end

    // Sample shift register: captures SD on SCK rise inside the selected slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= {SAMPLE_BITS{1'b0}};
        end else if (!en) begin
            shift_r <= {SAMPLE_BITS{1'b0}};
        end else if (cap_s) begin
            shift_r <= {shift_r[SAMPLE_BITS-2:0], i2s_sd};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Marks that the sample LSB was captured on the previous edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_bit_r <= 1'b0;
        end else if (!en) begin
            last_bit_r <= 1'b0;
        end else begin
            last_bit_r <= lsb_s;
        end
    end

    // Output strobe, rounded sample and startup discard counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r     <= {OUT_W{1'b0}};
            out_en_r   <= 1'b0;
            disc_cnt_r <= DISC_INIT;
        end else if (!en) begin
            dout_r     <= dout_r;
            out_en_r   <= 1'b0;
            disc_cnt_r <= DISC_INIT;
        end else if (last_bit_r) begin
            if (disc_cnt_r == {DISC_W{1'b0}}) begin
                dout_r     <= round_sat(shift_r[SAMPLE_BITS-1 -: OUT_W+1]);
                out_en_r   <= 1'b1;
                disc_cnt_r <= disc_cnt_r;
            end else begin
                dout_r     <= dout_r;
                out_en_r   <= 1'b0;
                disc_cnt_r <= disc_cnt_r - DISC_W'(1);
            end
        end else begin
            dout_r     <= dout_r;
            out_en_r   <= 1'b0;
            disc_cnt_r <= disc_cnt_r;
        end
    end

    assign i2s_sck = sck_r;
    assign i2s_ws  = ws_r;
    assign dout    = dout_r;
    assign out_en  = out_en_r;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: a microphone model plays a table of (left, right)
// 24-bit frames; expected strobes are queued as frames start and a monitor
// pops and compares them whenever a DUT raises out_en.
// Instance A: CHANNEL=0, DISCARD=0. Instance B: CHANNEL=1, DISCARD=2.
`timescale 1ns/1ps
module tb_i2s_mic_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        noise_sd = 1'b0;
    logic        mic_sd = 1'b1;
    logic        i2s_sd;
    logic        sck_a, ws_a, oe_a, sck_b, ws_b, oe_b;
    logic [15:0] dout_a, dout_b;

    assign i2s_sd = rst ? mic_sd : noise_sd;

    always #5 clk = ~clk;

    i2s_mic_rx #(.SCK_DIV(8), .BITS_PER_CH(32), .SAMPLE_BITS(24), .OUT_W(16),
                 .CHANNEL(0), .DISCARD(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .i2s_sd(i2s_sd),
        .i2s_sck(sck_a), .i2s_ws(ws_a), .dout(dout_a), .out_en(oe_a));

    i2s_mic_rx #(.SCK_DIV(8), .BITS_PER_CH(32), .SAMPLE_BITS(24), .OUT_W(16),
                 .CHANNEL(1), .DISCARD(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .i2s_sd(i2s_sd),
        .i2s_sck(sck_b), .i2s_ws(ws_b), .dout(dout_b), .out_en(oe_b));

    int total = 0;
    int bad = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    // Frame table: mic words and hand-rounded expectations.
    localparam int NF = 12;
    logic [23:0] tl [NF] = '{24'h123456, 24'h123480, 24'hFFFF80, 24'h800000,
                             24'h7FFF80, 24'h7FFF7F, 24'h000100, 24'h666666,
                             24'h0A0A0A, 24'h0C0C80, 24'hF00000, 24'h135791};
    logic [23:0] tr [NF] = '{24'h010000, 24'h020000, 24'h030000, 24'hABCDEF,
                             24'h7FFF80, 24'hFFFF80, 24'hABCDEF, 24'h777777,
                             24'h0B0B0B, 24'h0D0D0D, 24'h456789, 24'h246802};
    logic [15:0] ea [NF] = '{16'h1234, 16'h1235, 16'h0000, 16'h8000,
                             16'h7FFF, 16'h7FFF, 16'h0001, 16'h6666,
                             16'h0A0A, 16'h0C0D, 16'hF000, 16'h1358};
    logic [15:0] eb [NF] = '{16'h0000, 16'h0000, 16'h0300, 16'hABCE,
                             16'h7FFF, 16'h0000, 16'hABCE, 16'h7777,
                             16'h0000, 16'h0000, 16'h4568, 16'h2468};

    int pos = 0;
    int fidx = 0;
    int bfr = 0;
    logic [23:0] cur_l = 24'h000000;
    logic [23:0] cur_r = 24'h000000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sd_bit(input int p, input logic [23:0] l, input logic [23:0] r);
        int k;
        logic [23:0] w;
        k = p % 32;
        w = (p < 32) ? l : r;
        if (k >= 1 && k <= 24) return w[24-k];
        else return 1'b1;
    endfunction

    // Microphone model: counts SCK falls, starts a new frame at slot bit 1.
    initial begin : mic
        logic sck_q;
        sck_q = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (!rst || !en) begin
                pos = 0;
                bfr = 0;
            end else if (sck_q && !sck_a) begin
                pos = (pos == 63) ? 0 : pos + 1;
                if (pos == 1) begin
                    if (fidx < NF) begin
                        cur_l = tl[fidx];
                        cur_r = tr[fidx];
                        qa.push_back(ea[fidx]);
                        if (bfr >= 2) qb.push_back(eb[fidx]);
                    end else begin
                        cur_l = 24'h000000;
                        cur_r = 24'h000000;
                    end
                    bfr++;
                    fidx++;
                end
            end
            sck_q = sck_a;
            mic_sd = sd_bit(pos, cur_l, cur_r);
        end
    end

    // Monitor: pops expectations on each strobe, checks value, hold, latency, period.
    initial begin : monitor
        int n, rise_a, rise_b, last_an, last_bn;
        logic [15:0] last_a, last_b, prev_a, prev_b;
        logic spa, spb;
        n = 0; rise_a = -10; rise_b = -10; last_an = -1; last_bn = -1;
        last_a = 16'h0000; last_b = 16'h0000; prev_a = 16'h0000; prev_b = 16'h0000;
        spa = 1'b0; spb = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (!rst) begin
                last_a = 16'h0000; last_b = 16'h0000; last_an = -1; last_bn = -1;
            end else if (!en) begin
                last_an = -1; last_bn = -1;
            end
            if (sck_a && !spa) rise_a = n;
            if (sck_b && !spb) rise_b = n;
            if (oe_a) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected: got strobe with dout 0x%0h, want none", dout_a);
                end else begin
                    chk("a_dout", dout_a, qa.pop_front());
                end
                chk("a_hold", prev_a, last_a);
                chk("a_latency", n - rise_a, 1);
                if (last_an >= 0) chk("a_period", n - last_an, 1024);
                last_a = dout_a; last_an = n;
            end
            if (oe_b) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected: got strobe with dout 0x%0h, want none", dout_b);
                end else begin
                    chk("b_dout", dout_b, qb.pop_front());
                end
                chk("b_hold", prev_b, last_b);
                chk("b_latency", n - rise_b, 1);
                if (last_bn >= 0) chk("b_period", n - last_bn, 1024);
                last_b = dout_b; last_bn = n;
            end
            prev_a = dout_a; prev_b = dout_b;
            spa = sck_a; spb = sck_b;
        end
    end

    // Abort the running frame (en drop or reset) and check the pending state.
    task automatic abort(input bit use_rst, input logic [15:0] hold_a, input logic [15:0] hold_b);
        #1;
        if (use_rst) rst = 1'b0;
        else en = 1'b0;
        @(posedge clk); #1;
        chk("abort_sck_a", sck_a, 1'b0);
        chk("abort_sck_b", sck_b, 1'b0);
        chk("abort_ws_b", ws_b, 1'b0);
        chk("abort_dout_a", dout_a, hold_a);
        chk("abort_dout_b", dout_b, hold_b);
        chk("abort_pend_a", qa.size(), 1);
        chk("abort_pend_b", qb.size(), 1);
        qa.delete();
        qb.delete();
        repeat (50) @(negedge clk);
    endtask

    task automatic first_rise(input string name);
        int first;
        first = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            @(posedge clk); #1;
            if (sck_a) first = i;
        end
        chk(name, first, 8);
    endtask

    initial begin : main
        int wsfall, falls, done;
        logic sp;
        // Reset with SD toggling and en raised part-way.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            noise_sd = ~noise_sd;
            if (i == 10) en = 1'b1;
        end
        #1;
        chk("rst_sck", sck_a, 1'b0);
        chk("rst_ws", ws_a, 1'b0);
        chk("rst_dout_a", dout_a, 16'h0000);
        chk("rst_out_en_a", oe_a, 1'b0);
        chk("rst_dout_b", dout_b, 16'h0000);
        chk("rst_out_en_b", oe_b, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1;
        first_rise("first_rise_after_reset");

        // WS must rise on the 32nd SCK fall.
        falls = 0; wsfall = 0; sp = sck_a;
        for (int i = 0; i < 2000 && wsfall == 0; i++) begin
            @(posedge clk); #1;
            if (sp && !sck_a) begin
                falls++;
                if (ws_a) wsfall = falls;
            end
            sp = sck_a;
        end
        chk("ws_rise_fall_count", wsfall, 32);

        // Run frames 0..6, abort frame 7 at left slot bit k=10.
        done = 0;
        for (int i = 0; i < 12000 && done == 0; i++) begin
            @(negedge clk);
            if (fidx == 8 && pos == 10 && sck_a) done = 1;
        end
        chk("reach_abort_point", done, 1);
        abort(1'b0, 16'h0001, 16'hABCE);

        // Re-enable: B discards two frames again, then frames 8..11.
        #1;
        en = 1'b1;
        first_rise("first_rise_after_enable");
        done = 0;
        for (int i = 0; i < 6000 && done == 0; i++) begin
            @(negedge clk);
            if (fidx == 12 && pos == 10 && sck_a) done = 1;
        end
        chk("reach_reset_point", done, 1);
        abort(1'b1, 16'h0000, 16'h0000);
        chk("final_out_en_a", oe_a, 1'b0);
        chk("final_ws_a", ws_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
